// File: rtl/eight_to_thirty_two.sv
// Byte-to-word deserializer: packs four link bytes (byte 0 in [7:0]) into a
// 32-bit word held until acknowledged, with gap timeout and overrun reporting.
module eight_to_thirty_two #(
    parameter int unsigned TIMEOUT_CYC = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             div_8_clk,
    input  logic             rst_n,
    input  logic             rx_valid,
    input  logic [7:0]       data_in,
    input  logic             data_ack,
    output logic [31:0]      data_out,
    output logic             data_valid,
    output logic             err_timeout,
    output logic             err_overrun,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int unsigned TMR_W  = 8;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GOT1 = 2'd1,
        GOT2 = 2'd2,
        GOT3 = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [23:0]       buf_q, buf_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [WORD_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_overrun_q, err_overrun_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

    logic timeout_c;
    logic complete_c;

    // A byte arriving in the expiry cycle takes priority over the timeout
    assign timeout_c  = (state_q != IDLE) && !rx_valid &&
                        (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
    assign complete_c = rx_valid && (state_q == GOT3);

    // State register
    always_ff @(posedge div_8_clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (rx_valid) begin
            case (state_q)
                IDLE:    state_d = GOT1;
                GOT1:    state_d = GOT2;
                GOT2:    state_d = GOT3;
                GOT3:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else if (timeout_c) begin
            state_d = IDLE;
        end
    end

    // Datapath, gap timer and output next values
    always_comb begin
        buf_d         = buf_q;
        tmr_d         = tmr_q;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;
        word_cnt_d    = word_cnt_q;

        if (rx_valid) begin
            tmr_d = '0;
            case (state_q)
                IDLE:    buf_d[7:0]   = data_in;
                GOT1:    buf_d[15:8]  = data_in;
                GOT2:    buf_d[23:16] = data_in;
                default: buf_d        = buf_q;
            endcase
        end else if (state_q != IDLE) begin
            if (timeout_c) begin
                tmr_d         = '0;
                err_timeout_d = 1'b1;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end

        if (data_valid_q && data_ack) begin
            data_valid_d = 1'b0;
        end

        // A same-cycle ack frees the slot, so only an unacked word is lost
        if (complete_c) begin
            data_out_d    = {data_in, buf_q};
            data_valid_d  = 1'b1;
            word_cnt_d    = word_cnt_q + CNT_W'(1);
            err_overrun_d = data_valid_q && !data_ack;
        end
    end

    always_ff @(posedge div_8_clk) begin
        if (!rst_n) begin
            buf_q         <= '0;
            tmr_q         <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
            word_cnt_q    <= '0;
        end else begin
            buf_q         <= buf_d;
            tmr_q         <= tmr_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
            word_cnt_q    <= word_cnt_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;
    assign word_cnt    = word_cnt_q;

endmodule
